load_store_unit: RTL and testbench

Memory-stage load/store unit between the pipeline's MEM stage and the word-indexed data memory, which has a combinational read and a synchronous write. It accepts one byte-addressed request at a time and supports these access types:

- word, halfword and byte loads, signed and unsigned;
- word, halfword and byte stores.

It converts each request into word accesses. Sub-word stores are done as read-modify-write. Misaligned requests are flagged and never touch memory.

---
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-addressed requests become word accesses
// to a combinational-read, synchronous-write data memory; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         merge_q, merge_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                misalign_q, misalign_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         merged_s;
  logic                addr_hi_unused_s;

  // Upper address bits alias away by design.
  assign addr_hi_unused_s = ^addr[31:ADDR_W+2];

  function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] a);
    case (o)
      OP_LW, OP_SW:         return (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] o, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = 8'h00;
    endcase
    if (a[1]) begin
      h = d[31:16];
    end else begin
      h = d[15:0];
    end
    case (o)
      OP_LW:   return d;
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] o, input logic [1:0] a,
                                              input logic [31:0] old, input logic [31:0] sd);
    logic [31:0] res;
    res = old;
    if (o == OP_SB) begin
      case (a)
        2'd0:    res[7:0]   = sd[7:0];
        2'd1:    res[15:8]  = sd[7:0];
        2'd2:    res[23:16] = sd[7:0];
        2'd3:    res[31:24] = sd[7:0];
        default: res        = old;
      endcase
    end else if (o == OP_SH) begin
      if (a[1]) begin
        res[31:16] = sd[15:0];
      end else begin
        res[15:0] = sd[15:0];
      end
    end else begin
      res = old;
    end
    return res;
  endfunction

  assign merged_s = store_merge(op_q, lane_q, mem_rdata, wdata_q);

  // Next-state and next-output computation; strobes are decoded from the next state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rdata_d     = rdata_q;
    misalign_d  = misalign_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d       = op;
          lane_d     = addr[1:0];
          wdata_d    = wdata;
          rdata_d    = 32'h0000_0000;
          misalign_d = is_misaligned(op, addr[1:0]);
          mem_addr_d = addr[ADDR_W+1:2];
          if (is_misaligned(op, addr[1:0])) begin
            state_d = S_RESP;
          end else if (op <= OP_LBU) begin
            state_d = S_LOAD;
          end else if (op == OP_SW) begin
            state_d     = S_WRITE;
            mem_wdata_d = wdata;
          end else begin
            state_d = S_RMW_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        rdata_d = load_extract(op_q, lane_q, mem_rdata);
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d     = merged_s;
        mem_wdata_d = merged_s;
        state_d     = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    mem_read_d   = (state_d == S_LOAD) || (state_d == S_RMW_RD);
    mem_write_d  = (state_d == S_WRITE);
  end

  // State, latched request and registered outputs; reset drops mem_write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 3'b000;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      merge_q      <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      misalign_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      rdata_q      <= rdata_d;
      misalign_q   <= misalign_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign misalign   = misalign_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = {{(32-ADDR_W){1'b0}}, mem_addr_q};
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word memory model preloaded word[i] = i.
module tb_load_store_unit;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, resp_valid, misalign, mem_read, mem_write;
  logic [2:0]  op;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        preload;
  logic [31:0] mem [32];
  logic [26:0] mem_addr_hi_unused;

  int          n_vec = 0, n_err = 0;
  int          lat, rd_cyc, wr_cyc, wr_cnt, overlap = 0;
  logic [31:0] wr_addr, wr_data, got_rdata;
  logic        got_mis, resp_seen;
  logic        rv [8], rr [8], mr [8], mw [8];
  logic [31:0] wd [8], rd [8];

  load_store_unit #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata),
    .misalign(misalign), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata          = mem[mem_addr[4:0]];
  assign mem_addr_hi_unused = mem_addr[31:5];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
    end else if (mem_write) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp"}, 32'(resp_valid), 32'd0);
    check({tag, "_mis"}, 32'(misalign), 32'd0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_mrd"}, 32'(mem_read), 32'd0);
    check({tag, "_mwr"}, 32'(mem_write), 32'd0);
    check({tag, "_maddr"}, mem_addr, 32'h0);
    check({tag, "_mwdata"}, mem_wdata, 32'h0);
  endtask

  // One request; pulse=1 re-asserts req_valid with a different store while busy.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                     input bit pulse);
    @(negedge clk);
    op = o; addr = a; wdata = d; req_valid = 1'b1;
    lat = -1; rd_cyc = 0; wr_cyc = 0; wr_cnt = 0;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_read && rd_cyc == 0) rd_cyc = k;
      if (mem_write) begin
        wr_cnt++; wr_cyc = k; wr_addr = mem_addr; wr_data = mem_wdata;
      end
      if (mem_read && mem_write) overlap++;
      if (resp_valid) begin
        lat = k; got_rdata = rdata; got_mis = misalign;
      end
      if (k == 1 && pulse) begin
        op = OP_SW; addr = 32'h0; wdata = 32'h55;
      end else if (k == 1) begin
        req_valid = 1'b0;
      end
      if (k == 2) req_valid = 1'b0;
    end
    @(negedge clk);
    check("ready_after_resp", 32'(req_ready), 32'd1);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1; req_valid = 1'b0;
    op = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0; rst_n = 1'b1;
    check_idle("reset");

    run(OP_LW, 32'h0C, 32'h0, 1'b0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdcyc", 32'(rd_cyc), 32'd1);
    check("lw_rdata", got_rdata, 32'h3);
    check("lw_mis", 32'(got_mis), 32'd0);
    check("lw_nowr", 32'(wr_cnt), 32'd0);

    run(OP_LB, 32'h08, 32'h0, 1'b0);
    check("lb_rdata", got_rdata, 32'h2);

    run(OP_SB, 32'h15, 32'hAB, 1'b0);
    check("sb_rdcyc", 32'(rd_cyc), 32'd1);
    check("sb_wrcyc", 32'(wr_cyc), 32'd2);
    check("sb_waddr", wr_addr, 32'd5);
    check("sb_wdata", wr_data, 32'h0000AB05);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_rdata0", got_rdata, 32'h0);

    run(OP_LB, 32'h15, 32'h0, 1'b0);
    check("lb_sext", got_rdata, 32'hFFFFFFAB);
    run(OP_LBU, 32'h15, 32'h0, 1'b0);
    check("lbu_zext", got_rdata, 32'h000000AB);

    run(OP_SH, 32'h22, 32'h12348001, 1'b0);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_word8", mem[8], 32'h80010008);
    run(OP_LH, 32'h22, 32'h0, 1'b0);
    check("lh_sext", got_rdata, 32'hFFFF8001);
    run(OP_LW, 32'h20, 32'h0, 1'b0);
    check("lw_word8", got_rdata, 32'h80010008);

    run(OP_LW, 32'h06, 32'h0, 1'b0);
    check("mis_lw_lat", 32'(lat), 32'd1);
    check("mis_lw_flag", 32'(got_mis), 32'd1);
    check("mis_lw_rdata", got_rdata, 32'h0);
    check("mis_lw_nord", 32'(rd_cyc), 32'd0);

    run(OP_SH, 32'h13, 32'hFFFF, 1'b0);
    check("mis_sh_flag", 32'(got_mis), 32'd1);
    check("mis_sh_nowr", 32'(wr_cnt), 32'd0);
    check("mis_sh_word4", mem[4], 32'h4);

    run(OP_LB, 32'h33, 32'h0, 1'b0);
    check("lb_lane3_mis", 32'(got_mis), 32'd0);
    check("lb_lane3", got_rdata, 32'h0);
    run(OP_LW, 32'h8C, 32'h0, 1'b0);
    check("alias_lw", got_rdata, 32'h3);

    run(OP_SB, 32'h2D, 32'h77, 1'b1);
    check("busy_lat", 32'(lat), 32'd3);
    check("busy_wrcnt", 32'(wr_cnt), 32'd1);
    check("busy_wdata", wr_data, 32'h0000770B);
    check("busy_word0", mem[0], 32'h0);
    check("busy_word11", mem[11], 32'h0000770B);

    // SW held valid, then replaced by LW on the same held req_valid.
    @(negedge clk);
    op = OP_SW; addr = 32'h04; wdata = 32'hDEADBEEF; req_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      rv[k] = resp_valid; rr[k] = req_ready; mr[k] = mem_read; mw[k] = mem_write;
      wd[k] = mem_wdata; rd[k] = rdata;
      if (k == 1) begin
        op = OP_LW; wdata = 32'h0;
      end
      if (k == 4) req_valid = 1'b0;
    end
    check("b2b_sw_wr", 32'(mw[1]), 32'd1);
    check("b2b_sw_wdata", wd[1], 32'hDEADBEEF);
    check("b2b_rdy1", 32'(rr[1]), 32'd0);
    check("b2b_resp2", 32'(rv[2]), 32'd1);
    check("b2b_rdy2", 32'(rr[2]), 32'd0);
    check("b2b_rdy3", 32'(rr[3]), 32'd1);
    check("b2b_nord3", 32'(mr[3]), 32'd0);
    check("b2b_rd4", 32'(mr[4]), 32'd1);
    check("b2b_resp5", 32'(rv[5]), 32'd1);
    check("b2b_rdata", rd[5], 32'hDEADBEEF);
    check("b2b_resp6", 32'(rv[6]), 32'd0);

    // Reset during the WRITE cycle of SB 0x30.
    @(negedge clk);
    op = OP_SB; addr = 32'h30; wdata = 32'hEE; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_wr_before", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_wr_drop", 32'(mem_write), 32'd0);
    resp_seen = resp_valid;
    repeat (2) begin
      @(negedge clk);
      resp_seen = resp_seen | resp_valid;
    end
    rst_n = 1'b1;
    check_idle("post_rst");
    repeat (3) begin
      @(negedge clk);
      resp_seen = resp_seen | resp_valid;
    end
    check("rst_no_resp", 32'(resp_seen), 32'd0);
    check("rst_word12", mem[12], 32'h0000000C);
    check("rd_wr_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
